// File: rtl/ttl_534_bus_sequencer.sv
// ttl_534_bus_sequencer: round-robin sequencer for N 74LS534-type latches sharing one 8-bit bus.
// Ports:
//   clk, reset_n   - system clock, asynchronous active-low reset
//   req[N]         - level transfer requests, sampled only while IDLE
//   lck[N]         - per-latch capture clock, one-cycle high pulse in CAPTURE
//   oe_n[N]        - per-latch output enable, active low, at most one low
//   bus_valid      - high while the granted latch drives the bus
//   bus_ack        - consumer has taken the data, sampled only in DRIVE
//   done[N]        - one-cycle completion pulse to the finished requester
//   grant_id[3]    - current or last grantee index
//   busy           - high whenever the sequencer is not IDLE
//   err            - one-cycle watchdog abort pulse
// Optional feature: define BUS_TIMEOUT_EN to enable the DRIVE watchdog (limit TIMEOUT);
// without it DRIVE waits indefinitely for bus_ack and err is tied low.
module ttl_534_bus_sequencer #(
    parameter int N       = 4,
    parameter int TURN    = 1,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] lck,
    output logic [N-1:0] oe_n,
    output logic         bus_valid,
    input  logic         bus_ack,
    output logic [N-1:0] done,
    output logic [2:0]   grant_id,
    output logic         busy,
    output logic         err
);
    typedef enum logic [1:0] {IDLE, CAPTURE, DRIVE, TURNAROUND} state_t;

    state_t       state_q;
    logic [2:0]   rr_q;
    logic [2:0]   grant_q;
    logic [N-1:0] grant_oh_q;
    logic [2:0]   turn_q;
    logic [N-1:0] lck_q;
    logic [N-1:0] oe_n_q;
    logic         bus_valid_q;
    logic [N-1:0] done_q;
    logic         busy_q;
`ifdef BUS_TIMEOUT_EN
    logic [7:0]   wd_q;
    logic         err_q;
`endif

    logic [7:0]   req_pad;
    logic [3:0]   sum_d;
    logic [2:0]   pick_d;
    logic         hit_d;
    logic [2:0]   rr_next_d;
    logic [N-1:0] pick_oh_d;

    // Padding to 8 bits lets a 3-bit index address req for any N.
    assign req_pad   = 8'(req);
    assign rr_next_d = (pick_d == 3'(N - 1)) ? 3'd0 : pick_d + 3'd1;
    assign pick_oh_d = {{(N-1){1'b0}}, 1'b1} << pick_d;

    // Scan downward so the last hit written is the first set bit at or above rr_q (with wrap).
    always_comb begin
        pick_d = '0;
        hit_d  = 1'b0;
        sum_d  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            sum_d = {1'b0, rr_q} + 4'(i);
            if (sum_d >= 4'(N)) sum_d = sum_d - 4'(N);
            if (req_pad[sum_d[2:0]]) begin
                pick_d = sum_d[2:0];
                hit_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            grant_q     <= '0;
            grant_oh_q  <= '0;
            turn_q      <= '0;
            lck_q       <= '0;
            oe_n_q      <= '1;
            bus_valid_q <= 1'b0;
            done_q      <= '0;
            busy_q      <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            wd_q        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            lck_q  <= '0;
            done_q <= '0;
`ifdef BUS_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (hit_d) begin
                        grant_q    <= pick_d;
                        grant_oh_q <= pick_oh_d;
                        rr_q       <= rr_next_d;
                        lck_q      <= pick_oh_d;
                        busy_q     <= 1'b1;
                        state_q    <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    oe_n_q      <= ~grant_oh_q;
                    bus_valid_q <= 1'b1;
`ifdef BUS_TIMEOUT_EN
                    wd_q        <= '0;
`endif
                    state_q     <= DRIVE;
                end
                DRIVE: begin
                    if (bus_ack) begin
                        oe_n_q      <= '1;
                        bus_valid_q <= 1'b0;
                        done_q      <= grant_oh_q;
                        turn_q      <= 3'(TURN - 1);
                        state_q     <= TURNAROUND;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (wd_q == 8'(TIMEOUT - 1)) begin
                        // Abort: release the bus without a done pulse; rr_q is left as granted.
                        oe_n_q      <= '1;
                        bus_valid_q <= 1'b0;
                        err_q       <= 1'b1;
                        turn_q      <= 3'(TURN - 1);
                        state_q     <= TURNAROUND;
                    end else begin
                        wd_q <= wd_q + 8'd1;
                    end
`endif
                end
                TURNAROUND: begin
                    if (turn_q == 3'd0) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        turn_q <= turn_q - 3'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign lck       = lck_q;
    assign oe_n      = oe_n_q;
    assign bus_valid = bus_valid_q;
    assign done      = done_q;
    assign grant_id  = grant_q;
    assign busy      = busy_q;
`ifdef BUS_TIMEOUT_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif
endmodule

// File: tb/tb_ttl_534_bus_sequencer.sv
// tb_ttl_534_bus_sequencer: scoreboard bench for the round-robin latch bus sequencer (default build).
module tb_ttl_534_bus_sequencer;
    localparam int N    = 4;
    localparam int TURN = 1;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] req = '0;
    logic         bus_ack = 1'b0;
    logic [N-1:0] lck;
    logic [N-1:0] oe_n;
    logic         bus_valid;
    logic [N-1:0] done;
    logic [2:0]   grant_id;
    logic         busy;
    logic         err;

    int checks = 0;
    int fails = 0;
    int exp_q[$];
    int inv_viol = 0;
    int gap_viol = 0;
    int high_run = 0;
    bit seen_drive = 1'b0;

    ttl_534_bus_sequencer #(.N(N), .TURN(TURN)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .lck(lck), .oe_n(oe_n),
        .bus_valid(bus_valid), .bus_ack(bus_ack), .done(done),
        .grant_id(grant_id), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Bus invariants and turnaround gap, tallied every cycle and judged by test_contention.
    always @(negedge clk) begin
        if ($countones(~oe_n) > 1 || (lck & ~oe_n) != '0) inv_viol++;
        if (oe_n == '1) high_run++;
        else begin
            if (seen_drive && high_run > 0 && high_run < TURN + 1) gap_viol++;
            high_run = 0;
            seen_drive = 1'b1;
        end
    end

    task automatic wait_idle(input string name);
        for (int i = 0; i < 50 && busy !== 1'b0; i++) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_idle_timeout: busy=%b expected 0", name, busy);
        end
    endtask

    task automatic test_reset();
        int g;
        @(negedge clk);
        reset_n = 1'b0;
        req = 4'b1111;
        bus_ack = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (oe_n !== 4'b1111) begin fails++; $display("FAIL reset_oe_n: got %b expected 1111", oe_n); end
        checks++; if (lck !== 4'b0000) begin fails++; $display("FAIL reset_lck: got %b expected 0000", lck); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (bus_valid !== 1'b0) begin fails++; $display("FAIL reset_bus_valid: got %b expected 0", bus_valid); end
        checks++; if (done !== 4'b0000) begin fails++; $display("FAIL reset_done: got %b expected 0000", done); end
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (grant_id !== 3'd0) begin fails++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (lck !== 4'b0001) begin fails++; $display("FAIL reset_first_lck: got %b expected 0001", lck); end
        checks++; if (grant_id !== 3'd0) begin fails++; $display("FAIL reset_first_grant: got %0d expected 0", grant_id); end
        exp_q.push_back(0);
        req = '0;
        bus_ack = 1'b1;
        @(negedge clk);
        checks++; if (oe_n !== 4'b1110 || bus_valid !== 1'b1) begin fails++; $display("FAIL reset_first_drive: oe_n=%b bus_valid=%b expected 1110 1", oe_n, bus_valid); end
        @(negedge clk);
        g = exp_q.pop_front();
        checks++; if (done !== (4'b1 << g)) begin fails++; $display("FAIL reset_first_done: got %b expected %b", done, 4'b1 << g); end
        bus_ack = 1'b0;
        wait_idle("reset");
    endtask

    task automatic test_single();
        int g;
        req = 4'b0100;
        @(negedge clk);
        checks++; if (lck !== 4'b0100 || grant_id !== 3'd2 || busy !== 1'b1) begin fails++; $display("FAIL single_capture: lck=%b grant=%0d busy=%b expected 0100 2 1", lck, grant_id, busy); end
        exp_q.push_back(2);
        req = '0;
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            checks++; if (oe_n !== 4'b1011 || bus_valid !== 1'b1 || lck !== 4'b0000) begin fails++; $display("FAIL single_drive_c%0d: oe_n=%b bus_valid=%b lck=%b expected 1011 1 0000", c, oe_n, bus_valid, lck); end
            checks++; if (done !== 4'b0000) begin fails++; $display("FAIL single_early_done_c%0d: got %b expected 0000", c, done); end
        end
        bus_ack = 1'b1;
        @(negedge clk);
        g = exp_q.pop_front();
        checks++; if (done !== (4'b1 << g)) begin fails++; $display("FAIL single_done: got %b expected %b", done, 4'b1 << g); end
        checks++; if (oe_n !== 4'b1111 || bus_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL single_turn: oe_n=%b bus_valid=%b busy=%b expected 1111 0 1", oe_n, bus_valid, busy); end
        bus_ack = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 4'b0000) begin fails++; $display("FAIL single_idle: busy=%b done=%b expected 0 0000", busy, done); end
        checks++; if (grant_id !== 3'd2) begin fails++; $display("FAIL single_grant_hold: got %0d expected 2", grant_id); end
    endtask

    task automatic test_ack_outside();
        int g;
        bus_ack = 1'b1;
        req = '0;
        repeat (4) begin
            @(negedge clk);
            checks++; if (busy !== 1'b0 || done !== 4'b0000 || oe_n !== 4'b1111) begin fails++; $display("FAIL ack_idle: busy=%b done=%b oe_n=%b expected 0 0000 1111", busy, done, oe_n); end
        end
        req = 4'b1000;
        @(negedge clk);
        checks++; if (lck !== 4'b1000) begin fails++; $display("FAIL ack_capture: got %b expected 1000", lck); end
        exp_q.push_back(3);
        req = '0;
        @(negedge clk);
        checks++; if (oe_n !== 4'b0111) begin fails++; $display("FAIL ack_drive: got %b expected 0111", oe_n); end
        @(negedge clk);
        g = exp_q.pop_front();
        checks++; if (done !== (4'b1 << g) || oe_n !== 4'b1111) begin fails++; $display("FAIL ack_min_drive: done=%b oe_n=%b expected %b 1111", done, oe_n, 4'b1 << g); end
        wait_idle("ack");
        req = 4'b1001;
        @(negedge clk);
        checks++; if (lck !== 4'b0001) begin fails++; $display("FAIL rr_wrap: lck=%b expected 0001", lck); end
        exp_q.push_back(0);
        req = '0;
        repeat (2) @(negedge clk);
        g = exp_q.pop_front();
        checks++; if (done !== (4'b1 << g)) begin fails++; $display("FAIL rr_wrap_done: got %b expected %b", done, 4'b1 << g); end
        bus_ack = 1'b0;
        wait_idle("wrap");
    endtask

    task automatic test_round_robin();
        int nxt, ndone, g;
        int cnt[N];
        nxt = 0;
        ndone = 0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        req = 4'b1111;
        bus_ack = 1'b1;
        for (int c = 0; c < 200 && ndone < 20; c++) begin
            @(negedge clk);
            if (lck != '0) begin
                checks++; if (lck !== (4'b1 << nxt)) begin fails++; $display("FAIL rr_order: lck=%b expected %b", lck, 4'b1 << nxt); end
                exp_q.push_back(nxt);
                nxt = (nxt + 1) % N;
            end
            if (done != '0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL rr_unexpected_done: got %b expected none", done);
                end else begin
                    g = exp_q.pop_front();
                    if (done !== (4'b1 << g) || grant_id !== 3'(g)) begin fails++; $display("FAIL rr_done: done=%b grant=%0d expected %b %0d", done, grant_id, 4'b1 << g, g); end
                    cnt[g]++;
                end
                ndone++;
                if (ndone == 20) req = '0;
            end
        end
        checks++; if (ndone !== 20) begin fails++; $display("FAIL rr_done_count: got %0d expected 20", ndone); end
        for (int i = 0; i < N; i++) begin
            checks++; if (cnt[i] !== 5) begin fails++; $display("FAIL rr_per_req_%0d: got %0d expected 5", i, cnt[i]); end
        end
        bus_ack = 1'b0;
        wait_idle("rr");
        checks++; if (exp_q.size() !== 0) begin fails++; $display("FAIL rr_queue: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_contention();
        int idx, g;
        for (int c = 0; c < 10020; c++) begin
            if (c < 10000) begin
                req = 4'($urandom_range(0, 15));
                bus_ack = ($urandom_range(0, 2) == 0);
            end else begin
                req = '0;
                bus_ack = 1'b1;
            end
            @(negedge clk);
            if (lck != '0) begin
                idx = 0;
                for (int b = 0; b < N; b++) if (lck[b]) idx = b;
                checks++; if (!$onehot(lck) || grant_id !== 3'(idx)) begin fails++; $display("FAIL rand_capture: lck=%b grant=%0d", lck, grant_id); end
                exp_q.push_back(idx);
            end
            if (done != '0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL rand_unexpected_done: got %b expected none", done);
                end else begin
                    g = exp_q.pop_front();
                    if (done !== (4'b1 << g)) begin fails++; $display("FAIL rand_done: got %b expected %b", done, 4'b1 << g); end
                end
            end
        end
        bus_ack = 1'b0;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rand_drain: busy=%b expected 0", busy); end
        checks++; if (exp_q.size() !== 0) begin fails++; $display("FAIL rand_queue: got %0d pending expected 0", exp_q.size()); end
        checks++; if (inv_viol !== 0) begin fails++; $display("FAIL bus_invariant: got %0d violations expected 0", inv_viol); end
        checks++; if (gap_viol !== 0) begin fails++; $display("FAIL turnaround_gap: got %0d violations expected 0", gap_viol); end
    endtask

    task automatic test_reset_mid_drive();
        int g;
        wait_idle("mid_pre");
        req = 4'b0001;
        bus_ack = 1'b0;
        for (int i = 0; i < 10 && oe_n !== 4'b1110; i++) @(negedge clk);
        checks++; if (oe_n !== 4'b1110) begin fails++; $display("FAIL mid_reach_drive: oe_n=%b expected 1110", oe_n); end
        req = '0;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (oe_n !== 4'b1111 || bus_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL mid_async_release: oe_n=%b bus_valid=%b busy=%b expected 1111 0 0", oe_n, bus_valid, busy); end
        exp_q.delete();
        repeat (2) begin
            @(negedge clk);
            checks++; if (done !== 4'b0000) begin fails++; $display("FAIL mid_no_done: got %b expected 0000", done); end
        end
        reset_n = 1'b1;
        req = 4'b1111;
        @(negedge clk);
        checks++; if (lck !== 4'b0001) begin fails++; $display("FAIL mid_rr_reset: lck=%b expected 0001", lck); end
        exp_q.push_back(0);
        req = '0;
        bus_ack = 1'b1;
        repeat (2) @(negedge clk);
        g = exp_q.pop_front();
        checks++; if (done !== (4'b1 << g)) begin fails++; $display("FAIL mid_after_done: got %b expected %b", done, 4'b1 << g); end
        bus_ack = 1'b0;
        wait_idle("mid_post");
        checks++; if (inv_viol !== 0) begin fails++; $display("FAIL final_invariant: got %0d violations expected 0", inv_viol); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ack_outside();
        test_round_robin();
        test_contention();
        test_reset_mid_drive();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
